uart_tx_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one UART transmitter among NUM_REQ byte requesters.
- Sits between client logic and the TX_TOP instance inside the UART top.
- Accepts one byte per grant and launches it with a single-cycle TXDATA_VALID.
- Tracks TX_BUSY through a full frame before granting again.
- Holds the parity configuration stable for the whole frame.

---
 rtl/uart_arb_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 154 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional busy-timeout feature is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

    localparam int BYTE_W           = 8;
    localparam int BUSY_TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: returns the first set request bit found
// starting just above last_id and wrapping modulo NUM_REQ.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_id,
    output logic [IDW-1:0]     win,
    output logic               any_valid
);

    logic [IDW-1:0] idx_s;
    logic           found_s;

    // Walk the requesters in rotating priority order; the first hit wins.
    always_comb begin
        win       = {IDW{1'b0}};
        found_s   = 1'b0;
        idx_s     = {IDW{1'b0}};
        any_valid = |req;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s = IDW'((int'(last_id) + k) % NUM_REQ);
            if (!found_s && req[idx_s]) begin
                found_s = 1'b1;
                win     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter/sequencer sharing one UART transmitter between NUM_REQ
// byte requesters. One byte is accepted per grant, launched with a single-cycle
// TXDATA_VALID, and the next grant waits until the transmitter has gone busy
// and idle again. Parity configuration is latched at grant time.
// Define UART_ARB_TIMEOUT_EN to add a watchdog on the transmitter going busy
// (timeout_err output, BUSY_TIMEOUT parameter).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = 2
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
`endif
) (
    input  logic                      clk,
    input  logic                      ARST,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      cfg_par_en,
    input  logic                      cfg_par_typ,
    output logic [BYTE_W-1:0]         TX_P_DATA,
    output logic                      TXDATA_VALID,
    output logic                      TX_PAR_EN,
    output logic                      TX_PAR_TYP,
    input  logic                      TX_BUSY,
    output logic [IDW-1:0]            grant_id,
    output logic                      arb_busy
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TO_RAW = $clog2(BUSY_TIMEOUT + 1);
    localparam int TO_W   = (TO_RAW < 4) ? 4 : TO_RAW;
    logic [TO_W-1:0] cnt_r;
`endif

    arb_state_t     state_r;
    logic [IDW-1:0] last_id_r;
    logic [IDW-1:0] win_s;
    logic           any_valid_s;
    logic           grant_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr_pick (
        .req       (req_valid),
        .last_id   (last_id_r),
        .win       (win_s),
        .any_valid (any_valid_s)
    );

    // A grant needs an idle arbiter, an idle transmitter and a pending byte.
    assign grant_s = (state_r == IDLE) && any_valid_s && !TX_BUSY;

    // Accept pulse to the winner in the grant cycle; forced low during reset.
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (grant_s && !ARST) begin
            req_ready[win_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Frame sequencer: grant, launch, wait for busy to rise, wait for busy to fall.
    always_ff @(posedge clk or posedge ARST) begin
        if (ARST) begin
            state_r      <= IDLE;
            last_id_r    <= IDW'(NUM_REQ - 1);
            TX_P_DATA    <= {BYTE_W{1'b0}};
            TXDATA_VALID <= 1'b0;
            TX_PAR_EN    <= 1'b0;
            TX_PAR_TYP   <= 1'b0;
            grant_id     <= {IDW{1'b0}};
            arb_busy     <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_r        <= {TO_W{1'b0}};
            timeout_err  <= 1'b0;
`endif
        end else begin
            TXDATA_VALID <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeout_err  <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        TX_P_DATA    <= req_data[win_s*BYTE_W +: BYTE_W];
                        TX_PAR_EN    <= cfg_par_en;
                        TX_PAR_TYP   <= cfg_par_typ;
                        grant_id     <= win_s;
                        last_id_r    <= win_s;
                        TXDATA_VALID <= 1'b1;
                        arb_busy     <= 1'b1;
                        state_r      <= LAUNCH;
                    end else begin
                        arb_busy     <= 1'b0;
                        state_r      <= IDLE;
                    end
                end
                LAUNCH: begin
                    arb_busy <= 1'b1;
                    state_r  <= WAIT_BUSY;
`ifdef UART_ARB_TIMEOUT_EN
                    cnt_r    <= {TO_W{1'b0}};
`endif
                end
                WAIT_BUSY: begin
                    if (TX_BUSY) begin
                        arb_busy <= 1'b1;
                        state_r  <= WAIT_DONE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (cnt_r == TO_W'(BUSY_TIMEOUT - 1)) begin
                        arb_busy    <= 1'b0;
                        timeout_err <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        cnt_r    <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
                        arb_busy <= 1'b1;
                        state_r  <= WAIT_BUSY;
                    end
`else
                    else begin
                        arb_busy <= 1'b1;
                        state_r  <= WAIT_BUSY;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (!TX_BUSY) begin
                        arb_busy <= 1'b0;
                        state_r  <= IDLE;
                    end else begin
                        arb_busy <= 1'b1;
                        state_r  <= WAIT_DONE;
                    end
                end
                default: begin
                    arb_busy <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: expected launches are queued when
// requests are driven and popped when TXDATA_VALID is observed.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [3:0]  req_valid = 4'b0;
    logic [31:0] req_data = 32'h0;
    logic [3:0]  req_ready;
    logic        cfg_par_en = 1'b0;
    logic        cfg_par_typ = 1'b0;
    logic [7:0]  tx_p_data;
    logic        txdata_valid;
    logic        tx_par_en;
    logic        tx_par_typ;
    logic        tx_busy = 1'b0;
    logic [1:0]  grant_id;
    logic        arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
    logic        timeout_err;
    localparam int BT = 15;
`endif

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       pe;
        logic       pt;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .IDW(2)) dut (
        .clk          (clk),
        .ARST         (arst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .TX_P_DATA    (tx_p_data),
        .TXDATA_VALID (txdata_valid),
        .TX_PAR_EN    (tx_par_en),
        .TX_PAR_TYP   (tx_par_typ),
        .TX_BUSY      (tx_busy),
        .grant_id     (grant_id),
        .arb_busy     (arb_busy)
`ifdef UART_ARB_TIMEOUT_EN
        ,
        .timeout_err  (timeout_err)
`endif
    );

    task automatic push_exp(input logic [1:0] id, input logic [7:0] d, input logic pe, input logic pt);
        exp_t e;
        e.id = id; e.data = d; e.pe = pe; e.pt = pt;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tx_busy = 1'b0;
        req_valid = 4'b0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
    endtask

    // Waits (bounded) for a launch, checking the accept pulse and launch contents.
    task automatic check_launch(input string name);
        bit   rdy_prev = 1'b0;
        bit   done = 1'b0;
        exp_t e;
        logic [3:0] exp_rdy;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (txdata_valid === 1'b1) begin
                done = 1'b1;
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL %s: launch with empty scoreboard data=%h", name, tx_p_data);
                end else begin
                    e = sb.pop_front();
                    if ({tx_p_data, grant_id, tx_par_en, tx_par_typ} !== {e.data, e.id, e.pe, e.pt}) begin
                        bad++;
                        $display("FAIL %s: got data=%h id=%0d pe=%b pt=%b, expected data=%h id=%0d pe=%b pt=%b",
                                 name, tx_p_data, grant_id, tx_par_en, tx_par_typ, e.data, e.id, e.pe, e.pt);
                    end
                end
                total++;
                if (!rdy_prev) begin
                    bad++;
                    $display("FAIL %s latency: launch not one cycle after req_ready", name);
                end
            end else begin
                if (req_ready !== 4'b0) begin
                    total++;
                    exp_rdy = (sb.size() != 0) ? (4'b0001 << sb[0].id) : 4'b0000;
                    if (req_ready !== exp_rdy) begin
                        bad++;
                        $display("FAIL %s req_ready: got %b expected %b", name, req_ready, exp_rdy);
                    end
                    rdy_prev = 1'b1;
                end else begin
                    rdy_prev = 1'b0;
                end
                @(negedge clk);
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s: no launch within budget", name);
        end
    endtask

    // UART model: busy for n cycles; no accept or launch may appear meanwhile.
    task automatic uart_frame(input int n, input string name);
        bit ok = 1'b1;
        tx_busy = 1'b1;
        repeat (n) begin
            @(negedge clk);
            #1;
            if (req_ready !== 4'b0 || txdata_valid !== 1'b0) ok = 1'b0;
        end
        tx_busy = 1'b0;
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s frame: grant or launch seen while transmitter busy", name);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++;
        if ({req_ready, tx_p_data, txdata_valid, tx_par_en, tx_par_typ, grant_id, arb_busy} !== 17'h0) begin
            bad++;
            $display("FAIL reset_vals: got rdy=%b data=%h v=%b pe=%b pt=%b id=%0d busy=%b, expected all 0",
                     req_ready, tx_p_data, txdata_valid, tx_par_en, tx_par_typ, grant_id, arb_busy);
        end
        // Launch a byte and reset in the middle of WAIT_DONE.
        cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        req_data[7:0] = 8'h5A;
        req_valid = 4'b0001;
        push_exp(2'd0, 8'h5A, 1'b1, 1'b1);
        check_launch("reset_pre");
        tx_busy = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (arb_busy !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_state: arb_busy got %b expected 1", arb_busy);
        end
        arst = 1'b1;
        #1;
        total++;
        if ({req_ready, tx_p_data, txdata_valid, tx_par_en, tx_par_typ, grant_id, arb_busy} !== 17'h0) begin
            bad++;
            $display("FAIL reset_mid: got rdy=%b data=%h v=%b pe=%b pt=%b id=%0d busy=%b, expected all 0",
                     req_ready, tx_p_data, txdata_valid, tx_par_en, tx_par_typ, grant_id, arb_busy);
        end
        req_data[7:0] = 8'h3C;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b1;
        tx_busy = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        push_exp(2'd0, 8'h3C, 1'b0, 1'b1);
        check_launch("reset_after");
        req_valid = 4'b0;
        uart_frame(11, "reset_after");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single();
        bit ok = 1'b1;
        cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        push_exp(2'd0, 8'hA5, 1'b1, 1'b0);
        check_launch("single_1");
        repeat (4) begin
            @(negedge clk);
            #1;
            if (req_ready !== 4'b0 || txdata_valid !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL single_hold: second grant before transmitter frame, rdy=%b v=%b", req_ready, txdata_valid);
        end
        uart_frame(11, "single_1");
        push_exp(2'd0, 8'hA5, 1'b1, 1'b0);
        check_launch("single_2");
        req_valid = 4'b0;
        uart_frame(11, "single_2");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_all_four();
        logic [7:0] bytes [4];
        do_reset();
        bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'h32; bytes[3] = 8'h43;
        for (int i = 0; i < 4; i++) req_data[8*i +: 8] = bytes[i];
        cfg_par_en = 1'b0; cfg_par_typ = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) push_exp(2'(i % 4), bytes[i % 4], 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_launch($sformatf("rr_%0d", i));
            uart_frame(11, $sformatf("rr_%0d", i));
        end
        req_valid = 4'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cfg_hold();
        bit ok = 1'b1;
        cfg_par_en = 1'b1; cfg_par_typ = 1'b1;
        req_data[23:16] = 8'h77;
        req_valid = 4'b0100;
        push_exp(2'd2, 8'h77, 1'b1, 1'b1);
        check_launch("cfg_1");
        req_valid = 4'b0;
        tx_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            cfg_par_typ = ~cfg_par_typ;
            cfg_par_en  = ~cfg_par_en;
            #1;
            if (tx_par_typ !== 1'b1 || tx_par_en !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL cfg_hold: parity changed mid-frame pe=%b pt=%b expected 1 1", tx_par_en, tx_par_typ);
        end
        tx_busy = 1'b0;
        cfg_par_en = 1'b1; cfg_par_typ = 1'b0;
        req_data[23:16] = 8'h78;
        req_valid = 4'b0100;
        push_exp(2'd2, 8'h78, 1'b1, 1'b0);
        check_launch("cfg_2");
        req_valid = 4'b0;
        uart_frame(11, "cfg_2");
        repeat (2) @(negedge clk);
    endtask

    task automatic test_busy_block();
        bit ok = 1'b1;
        tx_busy = 1'b1;
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        req_data[15:8] = 8'h99;
        req_valid = 4'b0010;
        repeat (6) begin
            @(negedge clk);
            #1;
            if (req_ready !== 4'b0 || txdata_valid !== 1'b0) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL busy_block: grant while TX_BUSY high rdy=%b v=%b", req_ready, txdata_valid);
        end
        push_exp(2'd1, 8'h99, 1'b0, 1'b0);
        tx_busy = 1'b0;
        check_launch("busy_release");
        req_valid = 4'b0;
        uart_frame(11, "busy_release");
        repeat (2) @(negedge clk);
    endtask

`ifdef UART_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int first = 0;
        do_reset();
        cfg_par_en = 1'b0; cfg_par_typ = 1'b0;
        req_data[7:0] = 8'h11;
        req_data[15:8] = 8'h22;
        req_valid = 4'b0011;
        push_exp(2'd0, 8'h11, 1'b0, 1'b0);
        check_launch("to_first");
        for (int k = 1; k <= 40 && first == 0; k++) begin
            @(negedge clk);
            #1;
            if (timeout_err === 1'b1) first = k;
        end
        total++;
        if (first != BT + 1) begin
            bad++;
            $display("FAIL timeout_when: pulse at cycle %0d after launch, expected %0d", first, BT + 1);
        end
        push_exp(2'd1, 8'h22, 1'b0, 1'b0);
        check_launch("to_next");
        total++;
        if (timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_width: timeout_err got %b expected 0", timeout_err);
        end
        req_valid = 4'b0;
        uart_frame(11, "to_next");
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_cfg_hold();
        test_busy_block();
`ifdef UART_ARB_TIMEOUT_EN
        test_timeout();
`endif
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
